// File: rtl/multi_bound_counter_pkg.sv
// multi_bound_counter_pkg: shared FSM state and mode encodings
package multi_bound_counter_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  localparam logic MODE_SAT = 1'b0;
  localparam logic MODE_WRAP = 1'b1;
endpackage

// File: rtl/bound_counter_ch.sv
// bound_counter_ch: one bounded counter channel (FSM, count, limit, hit); MULTI_BOUND_COUNTER_ASSERT_EN adds checks
module bound_counter_ch
  import multi_bound_counter_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEFAULT_LIMIT = 200,
  parameter int RESTART = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             mode,
  input  logic             lw,
  input  logic [WIDTH-1:0] lv,
  output logic [WIDTH-1:0] count,
  output logic             hit,
  output logic             sat
);
  localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WIDTH-1:0] RESTART_V = WIDTH'(RESTART);
  state_t state, state_n;
  logic [WIDTH-1:0] lim, lim_n, count_n, wrap_v;
  logic at, clamp, hit_n, sat_n;
  // registers: state, count, limit and the registered flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      lim <= LIM_RST;
      hit <= 1'b0;
      sat <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      lim <= lim_n;
      hit <= hit_n;
      sat <= sat_n;
    end
  // next state: clear beats clamp beats HOLD exit beats counting; compares use the incoming limit
  always_comb begin
    lim_n = lw ? lv : lim;
    clamp = lw && lv < count;
    at = count == lim_n;
    wrap_v = RESTART_V < lim_n ? RESTART_V : lim_n;
    state_n = state;
    count_n = count;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else if (clamp)
      count_n = lv;
    else if (state == HOLD)
      state_n = lw && lv > count ? COUNT : HOLD;
    else if (en) begin
      state_n = COUNT;
      if (!at)
        count_n = count + 1'b1;
      else if (state == COUNT && mode == MODE_WRAP)
        count_n = wrap_v;
      else if (state == COUNT)
        state_n = HOLD;
    end
  end
  // outputs: hit only when the count/limit pair newly becomes equal, never for limit 0
  always_comb begin
    hit_n = lim_n != '0 && count_n == lim_n && (count_n != count || lim_n != lim);
    sat_n = state_n == HOLD;
  end
`ifdef MULTI_BOUND_COUNTER_ASSERT_EN
  a_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= lim);
  a_sat: assert property (@(posedge clk) disable iff (!rst_n) sat == (state == HOLD));
  a_hit: assert property (@(posedge clk) disable iff (!rst_n) hit |=> !hit || $past(lw));
`endif
endmodule

// File: rtl/multi_bound_counter.sv
// multi_bound_counter: CHANNELS independent bounded counters with shared limit-write port; MULTI_BOUND_COUNTER_ASSERT_EN enables checks
module multi_bound_counter
  import multi_bound_counter_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int CHANNELS = 4,
  parameter int DEFAULT_LIMIT = 200,
  parameter int RESTART = 1,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clear,
  input  logic                      mode,
  input  logic                      limit_we,
  input  logic [CW-1:0]             limit_ch,
  input  logic [WIDTH-1:0]          limit_val,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       hit,
  output logic [CHANNELS-1:0]       sat
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    bound_counter_ch #(
      .WIDTH(WIDTH),
      .DEFAULT_LIMIT(DEFAULT_LIMIT),
      .RESTART(RESTART)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[i]),
      .clear(clear[i]),
      .mode(mode),
      .lw(limit_we && limit_ch == CW'(i)),
      .lv(limit_val),
      .count(count[i*WIDTH +: WIDTH]),
      .hit(hit[i]),
      .sat(sat[i])
    );
  end
endmodule

// File: tb/tb_multi_bound_counter.sv
// tb_multi_bound_counter: directed scoreboard bench for multi_bound_counter
module tb_multi_bound_counter;
  localparam int W = 11;
  localparam int N = 4;
  typedef struct {
    string tag;
    int ch;
    logic [W-1:0] c;
    logic h;
    logic s;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] en, clear, hit, sat;
  logic mode, limit_we;
  logic [1:0] limit_ch;
  logic [W-1:0] limit_val;
  logic [N*W-1:0] count;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  multi_bound_counter dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clear(clear),
    .mode(mode),
    .limit_we(limit_we),
    .limit_ch(limit_ch),
    .limit_val(limit_val),
    .count(count),
    .hit(hit),
    .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic push(input string tag, input int ch, input int c, input bit h, input bit s);
    exp_t e;
    e.tag = tag;
    e.ch = ch;
    e.c = W'(c);
    e.h = h;
    e.s = s;
    q.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [W-1:0] cv;
    while (q.size() > 0) begin
      e = q.pop_front();
      cv = count[e.ch*W +: W];
      checks++;
      assert ({cv, hit[e.ch], sat[e.ch]} === {e.c, e.h, e.s})
      else begin
        errors++;
        $error("FAIL %s ch%0d: got count=%0d hit=%b sat=%b, want count=%0d hit=%b sat=%b",
               e.tag, e.ch, cv, hit[e.ch], sat[e.ch], e.c, e.h, e.s);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    en = '0;
    clear = '0;
    mode = 1'b0;
    limit_we = 1'b0;
    limit_ch = '0;
    limit_val = '0;
    #12;
    for (int i = 0; i < N; i++) push("reset", i, 0, 0, 0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    en = 4'b0001;
    for (int k = 1; k <= 210; k++) begin
      push("sat_run", 0, k <= 200 ? k : 200, k == 200, k > 200);
      tick();
    end
    limit_we = 1'b1;
    limit_ch = 2'd0;
    limit_val = 11'd300;
    push("lim_up", 0, 200, 0, 0);
    tick();
    limit_we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push("resume", 0, 200 + k, 0, 0);
      tick();
    end
    en = '0;
    limit_we = 1'b1;
    limit_ch = 2'd1;
    limit_val = 11'd5;
    push("lim_wr", 1, 0, 0, 0);
    tick();
    limit_we = 1'b0;
    mode = 1'b1;
    en = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      push("wrap", 1, k % 5 + 1, (k % 5) == 4, 0);
      if (k == 0) push("ch0_held", 0, 203, 0, 0);
      tick();
    end
    en = '0;
    mode = 1'b0;
    limit_we = 1'b1;
    limit_val = 11'd0;
    push("lim0_clamp", 1, 0, 0, 0);
    tick();
    limit_we = 1'b0;
    en = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      push("lim0_run", 1, 0, 0, 1);
      tick();
    end
    en = 4'b0100;
    go(149);
    push("ch2_150", 2, 150, 0, 0);
    tick();
    limit_we = 1'b1;
    limit_ch = 2'd2;
    limit_val = 11'd100;
    push("clamp", 2, 100, 1, 0);
    tick();
    limit_we = 1'b0;
    push("clamp_hold", 2, 100, 0, 1);
    tick();
    mode = 1'b1;
    push("mode_hold", 2, 100, 0, 1);
    tick();
    mode = 1'b0;
    en = 4'b1000;
    go(49);
    push("ch3_50", 3, 50, 0, 0);
    tick();
    clear = 4'b1000;
    push("clear", 3, 0, 0, 0);
    tick();
    clear = '0;
    en = '0;
    push("idle", 3, 0, 0, 0);
    tick();
    clear = 4'b1000;
    en = 4'b1000;
    limit_we = 1'b1;
    limit_ch = 2'd3;
    limit_val = 11'd7;
    push("clr_lim", 3, 0, 0, 0);
    tick();
    clear = '0;
    limit_we = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      push("lim7", 3, k, k == 7, 0);
      tick();
    end
    en = '0;
    push("lim7_held", 3, 7, 0, 0);
    tick();
    en = 4'b0001;
    go(2);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) push("rst_async", i, 0, 0, 0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    en = '0;
    push("rst_idle", 0, 0, 0, 0);
    tick();
    en = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      push("rst_lim", 3, k, 0, 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_bound_counter.md
MULTI_BOUND_COUNTER -- requirements
Module: multi_bound_counter

Interface
REQ-001 Parameter WIDTH, default 11, counter bit width (2..32).
REQ-002 Parameter CHANNELS, default 4, number of independent counters (1..16).
REQ-003 Parameter DEFAULT_LIMIT, default 200, per-channel limit after reset; SHALL fit in WIDTH bits.
REQ-004 Parameter RESTART, default 1, value loaded on wrap; SHALL be less than DEFAULT_LIMIT.
REQ-005 Ports SHALL be:
- clk  input  1  -- the block's single clock.
- rst_n  input  1  -- asynchronous, active-low reset.
- en  input  CHANNELS  -- per-channel count enable.
- clear  input  CHANNELS  -- per-channel synchronous clear.
- mode  input  1  -- 0 = saturate at limit, 1 = wrap to RESTART; global, sampled every cycle.
- limit_we  input  1  -- limit write strobe.
- limit_ch  input  $clog2(CHANNELS) (min 1)  -- limit write target channel.
- limit_val  input  WIDTH  -- limit write data.
- count  output  CHANNELS*WIDTH  -- packed counts; channel i at [i*WIDTH +: WIDTH].
- hit  output  CHANNELS  -- one-cycle pulse, count reached limit.
- sat  output  CHANNELS  -- level, channel in HOLD.

Function
REQ-006 Each channel SHALL run a 3-state FSM: IDLE, COUNT, HOLD; all outputs registered.
REQ-007 IDLE -> COUNT when en=1; the count increments in that same cycle (0 -> 1).
REQ-008 In COUNT with en=1 and count != limit, count SHALL increment by 1; en=0 holds count and state.
REQ-009 In COUNT with en=1 and count == limit: mode=0 -> HOLD, count unchanged; mode=1 -> count <= RESTART, state stays COUNT.
REQ-010 hit[i] SHALL pulse for exactly the one cycle after count[i] first becomes equal to limit[i].
REQ-011 sat[i] SHALL be 1 exactly while channel i is in HOLD.
REQ-012 HOLD SHALL exit only via clear (-> IDLE) or a limit write greater than count (-> COUNT); a mode change alone SHALL NOT exit HOLD.
REQ-013 clear[i] SHALL take priority over en[i]: count <= 0, state <= IDLE, hit suppressed.
REQ-014 A limit write SHALL update limit[limit_ch] at the next edge; if the new limit is below the current count, count SHALL clamp to the new limit in that same edge and hit SHALL pulse.
REQ-015 A simultaneous clear and limit write to the same channel SHALL apply both (count 0, new limit).
REQ-016 limit 0: the channel SHALL keep count at 0, and hit SHALL never assert.
REQ-017 The count SHALL never exceed limit; no arithmetic overflow at WIDTH bits.

Reset
REQ-018 On rst_n=0, asynchronously: every count = 0, every limit = DEFAULT_LIMIT, every state = IDLE, hit = 0, sat = 0.
REQ-019 Reset mid-count SHALL discard all state, including written limits; counting resumes only after rst_n=1 and en=1.

Configuration
REQ-020 Macro MULTI_BOUND_COUNTER_ASSERT_EN defined: concurrent assertions compiled in, covering count <= limit, sat == (state == HOLD), and hit one cycle wide; a violation is reported at simulation time.
REQ-021 Macro undefined: no assertion code is present; RTL behaviour is identical.

Structure
REQ-022 Package multi_bound_counter_pkg SHALL hold the FSM state enum (IDLE, COUNT, HOLD) and the mode encoding constants.
REQ-023 Sub-module bound_counter_ch (one channel: FSM, count, limit, hit) SHALL be instantiated CHANNELS times by a generate loop; the top SHALL decode limit_we/limit_ch and pack the outputs.

Verification
REQ-024 Defaults, mode=0, en[0]=1 for 210 cycles -> count[0] reaches 200 at cycle 200; hit[0] pulses once; sat[0]=1 and count holds 200 thereafter.
REQ-025 mode=1, limit[1]=5, en[1] held -> count sequence 1,2,3,4,5,1,2,...; hit[1] pulses each time count reaches 5.
REQ-026 Channel 2 at count 150, write limit_val=100 -> count[2]=100 next cycle, hit[2] pulses, then HOLD (mode=0).
REQ-027 Channel 0 in HOLD at 200, write limit_val=300 -> sat[0] drops; count continues 201, 202, ... with en=1.
REQ-028 clear[3] and en[3] both asserted at count 50 -> count[3]=0, state IDLE, hit[3]=0; rst_n pulsed low mid-count -> all counts 0 and limits 200 immediately.
